// File: rtl/deadlock_multi_monitor.sv
// Deadlock monitor: flags persistent axis stalls or all-idle/blocked instances.
// Build option: DEADLOCK_MONITOR_STICKY_EN keeps BLOCKED until clear or reset.
module deadlock_multi_monitor #(
  parameter int NUM_AXIS       = 3,
  parameter int NUM_INST       = 3,
  parameter int PERSIST_CYCLES = 1,
  parameter int CNT_W          = 16,
  localparam int IW = (NUM_INST > 0) ? NUM_INST : 1,
  localparam int AW = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [IW-1:0]    inst_idle_sigs,
  input  logic [IW-1:0]    inst_block_sigs,
  input  logic             clear,
  output logic             block,
  output logic             block_src,
  output logic [AW-1:0]    block_axis_id,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SUSPECT,
    BLOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      pcnt_q, pcnt_d;
  logic             src_d;
  logic [AW-1:0]    id_d;
  logic [CNT_W-1:0] cnt_d;
  logic             axis_hit, inst_hit, cond, enter;
  logic [AW-1:0]    first_id;

  always_comb begin
    axis_hit = |axis_block_sigs;
    first_id = '0;
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (axis_block_sigs[i]) first_id = AW'(i);
    end
  end

  if (NUM_INST > 0) begin : g_inst
    assign inst_hit = (&(inst_idle_sigs | inst_block_sigs))
                    & (|inst_block_sigs);
  end else begin : g_no_inst
    assign inst_hit = 1'b0;
  end

  assign cond = axis_hit | inst_hit;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    src_d   = block_src;
    id_d    = block_axis_id;
    cnt_d   = stall_cnt;
    enter   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      pcnt_d  = '0;
      src_d   = 1'b0;
      id_d    = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cond) begin
            if (PERSIST_CYCLES == 1) begin
              enter = 1'b1;
            end else begin
              state_d = SUSPECT;
              pcnt_d  = 16'd1;
            end
          end
        end
        SUSPECT: begin
          if (!cond) begin
            state_d = IDLE;
            pcnt_d  = '0;
          end else if (pcnt_q + 16'd1 == 16'(PERSIST_CYCLES)) begin
            enter = 1'b1;
          end else begin
            pcnt_d = pcnt_q + 16'd1;
          end
        end
        BLOCKED: begin
          if (stall_cnt != '1) cnt_d = stall_cnt + 1'b1;
`ifdef DEADLOCK_MONITOR_STICKY_EN
          state_d = BLOCKED;
`else
          if (!cond) state_d = IDLE;
`endif
        end
        default: begin
          state_d = IDLE;
          pcnt_d  = '0;
        end
      endcase
      // Capture the source from the inputs of the entry cycle only
      if (enter) begin
        state_d = BLOCKED;
        pcnt_d  = '0;
        src_d   = !axis_hit;
        id_d    = axis_hit ? first_id : '0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pcnt_q        <= '0;
      block         <= 1'b0;
      block_src     <= 1'b0;
      block_axis_id <= '0;
      stall_cnt     <= '0;
    end else begin
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      block         <= (state_d == BLOCKED);
      block_src     <= src_d;
      block_axis_id <= id_d;
      stall_cnt     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_deadlock_multi_monitor.sv
// Directed bench for deadlock_multi_monitor: P=1 vector table plus
// P=4 persistence, saturation, clear and async reset sequences.
module tb_deadlock_multi_monitor;

  logic       clock;
  logic       reset;
  logic [2:0] axis;
  logic [2:0] idle;
  logic [2:0] blk;
  logic       clr;

  logic       b1, s1;
  logic [1:0] id1;
  logic [3:0] c1;
  logic       b4, s4;
  logic [1:0] id4;
  logic [15:0] c4;

  int n_run;
  int n_fail;

  deadlock_multi_monitor #(
    .NUM_AXIS(3), .NUM_INST(3), .PERSIST_CYCLES(1), .CNT_W(4)
  ) u_p1 (
    .clock(clock), .reset(reset),
    .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(blk), .clear(clr),
    .block(b1), .block_src(s1),
    .block_axis_id(id1), .stall_cnt(c1)
  );

  deadlock_multi_monitor #(
    .NUM_AXIS(3), .NUM_INST(3), .PERSIST_CYCLES(4), .CNT_W(16)
  ) u_p4 (
    .clock(clock), .reset(reset),
    .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(blk), .clear(clr),
    .block(b4), .block_src(s4),
    .block_axis_id(id4), .stall_cnt(c4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] axis;
    logic [2:0] idle;
    logic [2:0] blk;
    logic       clr;
    logic       e_block;
    logic       e_src;
    logic [1:0] e_id;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tv [18];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    axis  = '0;
    idle  = '0;
    blk   = '0;
    clr   = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b0;
    axis   = '0;
    idle   = '0;
    blk    = '0;
    clr    = 1'b0;

    tv[0]  = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0};
    tv[1]  = '{3'b000, 3'b101, 3'b010, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0};
    tv[2]  = '{3'b000, 3'b101, 3'b010, 1'b0, 1'b1, 1'b1, 2'd0, 4'd1};
`ifdef DEADLOCK_MONITOR_STICKY_EN
    tv[3]  = '{3'b000, 3'b001, 3'b010, 1'b0, 1'b1, 1'b1, 2'd0, 4'd2};
    tv[4]  = '{3'b000, 3'b001, 3'b010, 1'b0, 1'b1, 1'b1, 2'd0, 4'd3};
`else
    tv[3]  = '{3'b000, 3'b001, 3'b010, 1'b0, 1'b0, 1'b1, 2'd0, 4'd2};
    tv[4]  = '{3'b000, 3'b001, 3'b010, 1'b0, 1'b0, 1'b1, 2'd0, 4'd2};
`endif
    tv[5]  = '{3'b000, 3'b001, 3'b010, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0};
    tv[6]  = '{3'b110, 3'b101, 3'b010, 1'b0, 1'b1, 1'b0, 2'd1, 4'd0};
    tv[7]  = '{3'b001, 3'b101, 3'b010, 1'b0, 1'b1, 1'b0, 2'd1, 4'd1};
    tv[8]  = '{3'b001, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 2'd1, 4'd2};
    tv[9]  = '{3'b001, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0};
    tv[10] = '{3'b001, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0};
    tv[11] = '{3'b100, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1};
`ifdef DEADLOCK_MONITOR_STICKY_EN
    tv[12] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0, 4'd2};
    tv[13] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0, 4'd3};
`else
    tv[12] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2};
    tv[13] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2};
`endif
    tv[14] = '{3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0};
    tv[15] = '{3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0};
    tv[16] = '{3'b000, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0};
    tv[17] = '{3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0};

    #2;
    chk("reset block", {15'd0, b1}, 16'd0);
    chk("reset src", {15'd0, s1}, 16'd0);
    chk("reset id", {14'd0, id1}, 16'd0);
    chk("reset cnt", {12'd0, c1}, 16'd0);
    chk("reset p4 block", {15'd0, b4}, 16'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      axis = tv[i].axis;
      idle = tv[i].idle;
      blk  = tv[i].blk;
      clr  = tv[i].clr;
      step();
      chk($sformatf("vec%0d block", i), {15'd0, b1}, {15'd0, tv[i].e_block});
      chk($sformatf("vec%0d src", i), {15'd0, s1}, {15'd0, tv[i].e_src});
      chk($sformatf("vec%0d id", i), {14'd0, id1}, {14'd0, tv[i].e_id});
      chk($sformatf("vec%0d cnt", i), {12'd0, c1}, {12'd0, tv[i].e_cnt});
    end

    // Saturation of the 4-bit stall counter
    do_reset();
    axis = 3'b010;
    step();
    chk("sat entry block", {15'd0, b1}, 16'd1);
    chk("sat entry cnt", {12'd0, c1}, 16'd0);
    for (int k = 1; k < 20; k++) step();
    chk("sat cnt", {12'd0, c1}, 16'd15);
    chk("sat id", {14'd0, id1}, 16'd1);
    axis = 3'b000;
    step();
`ifdef DEADLOCK_MONITOR_STICKY_EN
    chk("sat drop block", {15'd0, b1}, 16'd1);
`else
    chk("sat drop block", {15'd0, b1}, 16'd0);
`endif
    chk("sat drop cnt", {12'd0, c1}, 16'd15);
    step();
    chk("sat hold cnt", {12'd0, c1}, 16'd15);

    // Persistence: four cycles of cond flag on the fourth edge
    do_reset();
    axis = 3'b100;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("p4 edge%0d block", k), {15'd0, b4},
          (k == 4) ? 16'd1 : 16'd0);
    end
    chk("p4 src", {15'd0, s4}, 16'd0);
    chk("p4 id", {14'd0, id4}, 16'd2);
    chk("p4 cnt", c4, 16'd0);

    // Three cycles then drop: never flags
    do_reset();
    axis = 3'b100;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("p4 short%0d block", k), {15'd0, b4}, 16'd0);
    end
    axis = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("p4 drop%0d block", k), {15'd0, b4}, 16'd0);
    end

    // Asynchronous reset mid-SUSPECT, then a fresh persistence window
    do_reset();
    axis = 3'b100;
    step();
    step();
    chk("pre-rst p1 block", {15'd0, b1}, 16'd1);
    chk("pre-rst p1 cnt", {12'd0, c1}, 16'd1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("arst p1 block", {15'd0, b1}, 16'd0);
    chk("arst p1 id", {14'd0, id1}, 16'd0);
    chk("arst p1 cnt", {12'd0, c1}, 16'd0);
    chk("arst p4 block", {15'd0, b4}, 16'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("rel edge%0d p4 block", k), {15'd0, b4},
          (k == 4) ? 16'd1 : 16'd0);
      chk($sformatf("rel edge%0d p1 block", k), {15'd0, b1}, 16'd1);
    end
    chk("rel p4 id", {14'd0, id4}, 16'd2);
    chk("rel p1 cnt", {12'd0, c1}, 16'd3);

    // Clear overrides BLOCKED in either build
    clr = 1'b1;
    axis = 3'b000;
    step();
    chk("clr p4 block", {15'd0, b4}, 16'd0);
    chk("clr p4 id", {14'd0, id4}, 16'd0);
    chk("clr p4 cnt", c4, 16'd0);
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/deadlock_multi_monitor.md
DEADLOCK_MULTI_MONITOR -- requirements
Module: deadlock_multi_monitor

Interface
REQ-001 SHALL have parameter NUM_AXIS, default 3: number of axis block-signal channels (>=1).
REQ-002 SHALL have parameter NUM_INST, default 3: number of monitored sub-instances (>=0; 0 disables the instance term).
REQ-003 SHALL have parameter PERSIST_CYCLES, default 1: consecutive cycles the block condition must hold before flagging (1..65535).
REQ-004 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-005 SHALL have ports: clock input 1 (sole clock; all logic on its rising edge); reset input 1 (asynchronous, active-low).
REQ-006 SHALL have ports: axis_block_sigs input NUM_AXIS (per-channel axis-stall flags); inst_idle_sigs input max(NUM_INST,1) (sub-instance idle); inst_block_sigs input max(NUM_INST,1) (sub-instance blocked); clear input 1 (synchronous clear of the flag and capture).
REQ-007 SHALL have ports: block output 1 (deadlock flag); block_src output 1 (0 = axis term, 1 = instance term); block_axis_id output clog2(NUM_AXIS) (captured channel index); stall_cnt output CNT_W (cycles spent in BLOCKED).

Function
REQ-008 axis_hit SHALL be the OR of all axis_block_sigs bits.
REQ-009 inst_hit SHALL be 1 iff NUM_INST>0, every instance has idle|block set, and at least one block bit is set; otherwise 0.
REQ-010 cond SHALL be axis_hit | inst_hit.
REQ-011 FSM states SHALL be IDLE, SUSPECT, BLOCKED, with a persistence counter pcnt.
REQ-012 IDLE: cond=1 and PERSIST_CYCLES=1 -> BLOCKED; cond=1 and PERSIST_CYCLES>1 -> SUSPECT with pcnt=1; else stay.
REQ-013 SUSPECT: cond=0 -> IDLE with pcnt=0; cond=1 -> pcnt+1, entering BLOCKED on the edge where pcnt+1 equals PERSIST_CYCLES.
REQ-014 Timing: with cond high on cycles t..t+P-1, block SHALL be 1 from edge t+P onward; with P=1 this is a one-cycle registered delay.
REQ-015 block SHALL be registered and equal to (state==BLOCKED).
REQ-016 On the transition into BLOCKED, block_src and block_axis_id SHALL be captured from that cycle's inputs.
REQ-017 block_src SHALL be 0 if axis_hit, else 1; axis wins when both terms are active.
REQ-018 block_axis_id SHALL be the lowest-index set axis bit, or 0 when block_src=1.
REQ-019 Captured values SHALL hold while in BLOCKED and are not updated by later input changes.
REQ-020 stall_cnt SHALL clear to 0 on entry to BLOCKED and then increment once per cycle in BLOCKED, saturating at all-ones.
REQ-021 stall_cnt SHALL hold its value after leaving BLOCKED until the next entry.
REQ-022 BLOCKED exit (non-sticky build) SHALL be: cond=0 -> IDLE, with block low on the next edge.
REQ-023 clear=1 SHALL force IDLE with pcnt=0, block_src=0, block_axis_id=0 and stall_cnt=0 on the next edge, taking priority over all transitions.
REQ-024 If clear and cond are both 1, cond SHALL be re-evaluated from IDLE on the following cycle.

Reset
REQ-025 reset=0 SHALL asynchronously force state=IDLE, pcnt=0, block=0, block_src=0, block_axis_id=0 and stall_cnt=0, regardless of clock.
REQ-026 Reset asserted mid-SUSPECT or mid-BLOCKED SHALL discard all progress; after release, persistence counting restarts from zero.
REQ-027 Deassertion of reset SHALL take effect at the first rising clock edge at which reset=1.

Configuration
REQ-028 With macro DEADLOCK_MONITOR_STICKY_EN defined, BLOCKED SHALL be left only via clear or reset, and cond=0 SHALL be ignored there.
REQ-029 Without the macro, the REQ-022 exit rule SHALL apply; stall_cnt and all other behaviour SHALL be identical in both builds.

Verification
REQ-030 Persistence: P=4, axis_block_sigs=3'b100 for 4 cycles -> block=1 at edge 4, block_src=0, block_axis_id=2; holding 3 cycles then dropping -> block stays 0.
REQ-031 Instance term: NUM_INST=3, idle=3'b101, block=3'b010, axis=0, P=1 -> block=1 on the next edge, block_src=1; idle=3'b001, block=3'b010 -> no flag.
REQ-032 Priority/capture: axis=3'b110 and a valid inst_hit on the same cycle -> block_src=0, block_axis_id=1; changing axis to 3'b001 while BLOCKED -> id stays 1.
REQ-033 Saturation: CNT_W=4, hold cond 20 cycles in BLOCKED -> stall_cnt reaches 15 and holds; drop cond (non-sticky) -> block=0, stall_cnt stays 15.
REQ-034 Sticky/clear: with STICKY_EN, drop cond in BLOCKED -> block stays 1; pulse clear -> block=0 and stall_cnt=0 next edge.
REQ-035 Async reset: assert reset=0 mid-SUSPECT between clock edges -> all outputs 0 immediately; release with cond held high -> block after a fresh P cycles.
